// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the framebuffer scheduler.
//   - default geometry (WIDTH, HEIGHT, ADDR_W, SCROLL_DIV)
//   - row/column index widths used by the address generator
//   - scheduler state encoding
//   - row_mod(): wrap a row sum into 0..HEIGHT-1 by one compare-subtract
package fb_pkg;

  localparam int FB_WIDTH      = 320;
  localparam int FB_HEIGHT     = 240;
  localparam int FB_ADDR_W     = 17;
  localparam int FB_SCROLL_DIV = 4;

  // Row index width (holds 0..HEIGHT-1) and scan column width.
  localparam int ROW_W = 8;
  localparam int COL_W = 9;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_VIDEO = 2'd1,
    ST_WRITE = 2'd2,
    ST_WAIT  = 2'd3
  } fb_state_t;

  // Both operands of the sum are already below HEIGHT, so a single
  // conditional subtract is enough to bring the result back into range.
  function automatic logic [ROW_W-1:0] row_mod(input logic [ROW_W:0] sum,
                                               input logic [ROW_W:0] height);
    logic [ROW_W:0] r;
    r = (sum >= height) ? (sum - height) : sum;
    return r[ROW_W-1:0];
  endfunction

endpackage

// File: rtl/fb_row_addr.sv
// fb_row_addr: combinational linear pixel address addr = row*WIDTH + col.
// The multiply is unrolled at elaboration into a chain of shifted adds, one
// per set bit of WIDTH (320 = 256 + 64 gives two adders).
// Ports:
//   row  in  ROW_W   framebuffer row
//   col  in  COL_W   column within the row
//   addr out ADDR_W  RAM address
module fb_row_addr
  import fb_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] W_BITS = ADDR_W'(WIDTH);

  logic [ADDR_W-1:0] row_ext;
  logic [ADDR_W-1:0] acc [0:ADDR_W];

  assign row_ext = ADDR_W'(row);
  assign acc[0]  = ADDR_W'(col);

  generate
    for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_term
      if (W_BITS[gi]) begin : g_add
        assign acc[gi+1] = acc[gi] + (row_ext << gi);
      end else begin : g_skip
        assign acc[gi+1] = acc[gi];
      end
    end
  endgenerate

  assign addr = acc[ADDR_W];

endmodule

// File: rtl/fb_scheduler.sv
// fb_scheduler: owns the single-port pixel RAM and time-shares it between
// LCD scan-out reads (visible time) and waterfall line writes (lower
// blanking). Also runs the post-reset clear and keeps the scroll offset.
//
// Build option: define FB_SCHED_CLEAR_EN to clear the whole RAM after each
// reset (state CLEAR). Without it, reset goes straight to VIDEO and the RAM
// keeps whatever it held.
//
// Ports (all outputs registered, single clock clk, sync active-low resetn):
//   clk, resetn          clock / synchronous active-low reset
//   visible, lower_blank LCD timing qualifiers
//   x, y                 LCD scan column / row
//   sample_valid, sample renderer handshake and 8-bit sample
//   sample_ack           one-cycle pulse when the sample is captured
//   ram_addr, ram_wdata, ram_we   RAM port
//   scroll_row           circular scroll offset 0..HEIGHT-1
//   busy                 high while CLEAR or WRITE is driving writes
module fb_scheduler
  import fb_pkg::*;
#(
  parameter int WIDTH      = FB_WIDTH,
  parameter int HEIGHT     = FB_HEIGHT,
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int SCROLL_DIV = FB_SCROLL_DIV
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              visible,
  input  logic              lower_blank,
  input  logic [8:0]        x,
  input  logic [7:0]        y,
  input  logic              sample_valid,
  input  logic [7:0]        sample,
  output logic              sample_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  output logic [7:0]        scroll_row,
  output logic              busy
);

  localparam int FC_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(WIDTH - 1);
  localparam logic [FC_W-1:0]   LAST_FRAME = FC_W'(SCROLL_DIV - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(HEIGHT - 1);
  localparam logic [ROW_W:0]    HEIGHT_EXT = (ROW_W + 1)'(HEIGHT);

`ifdef FB_SCHED_CLEAR_EN
  localparam fb_state_t RESET_STATE = ST_CLEAR;
`else
  localparam fb_state_t RESET_STATE = ST_VIDEO;
`endif

  fb_state_t         state_reg;
  logic [FC_W-1:0]   frame_cnt_reg;
  logic              lb_prev_reg;
  logic [ROW_W-1:0]  target_row_reg;
  logic [7:0]        sample_reg;
  logic [COL_W-1:0]  col_reg;
  logic [ADDR_W-1:0] clr_addr_reg;

  logic              lb_rise;
  logic              frame_wrap;
  logic              scroll_event;
  logic [ROW_W-1:0]  scan_row;
  logic [ROW_W-1:0]  addr_row;
  logic [COL_W-1:0]  addr_col;
  logic [ADDR_W-1:0] row_addr;

  assign lb_rise      = lower_blank & ~lb_prev_reg;
  assign frame_wrap   = (frame_cnt_reg == LAST_FRAME);
  assign scroll_event = (state_reg == ST_VIDEO) && lb_rise && frame_wrap && sample_valid;
  assign scan_row     = row_mod({1'b0, y} + {1'b0, scroll_row}, HEIGHT_EXT);

  // One address generator serves both paths. On the scroll event itself the
  // column-0 write address of the old scroll row is issued, so the first
  // write lands in the same cycle as sample_ack.
  always_comb begin
    addr_row = scan_row;
    addr_col = x;
    if (state_reg == ST_WRITE) begin
      addr_row = target_row_reg;
      addr_col = col_reg;
    end else if (scroll_event) begin
      addr_row = scroll_row;
      addr_col = '0;
    end
  end

  fb_row_addr #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_row_addr (
    .row  (addr_row),
    .col  (addr_col),
    .addr (row_addr)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= RESET_STATE;
      frame_cnt_reg  <= '0;
      lb_prev_reg    <= 1'b0;
      target_row_reg <= '0;
      sample_reg     <= '0;
      col_reg        <= '0;
      clr_addr_reg   <= '0;
      sample_ack     <= 1'b0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
      ram_we         <= 1'b0;
      scroll_row     <= '0;
      busy           <= 1'b0;
    end else begin
      lb_prev_reg <= lower_blank;
      sample_ack  <= 1'b0;

      case (state_reg)
        ST_CLEAR: begin
          ram_we    <= 1'b1;
          ram_wdata <= '0;
          ram_addr  <= clr_addr_reg;
          busy      <= 1'b1;
          if (clr_addr_reg == LAST_ADDR) begin
            state_reg <= ST_VIDEO;
          end else begin
            clr_addr_reg <= clr_addr_reg + ADDR_W'(1);
          end
        end

        ST_VIDEO: begin
          ram_we    <= 1'b0;
          ram_wdata <= '0;
          busy      <= 1'b0;
          ram_addr  <= visible ? row_addr : '0;
          if (lb_rise) begin
            frame_cnt_reg <= frame_wrap ? '0 : frame_cnt_reg + FC_W'(1);
            if (scroll_event) begin
              // Column 0 never exceeds the sample, so its data is 0.
              sample_reg     <= sample;
              sample_ack     <= 1'b1;
              target_row_reg <= scroll_row;
              scroll_row     <= (scroll_row == LAST_ROW) ? '0 : scroll_row + ROW_W'(1);
              ram_we         <= 1'b1;
              ram_addr       <= row_addr;
              busy           <= 1'b1;
              col_reg        <= COL_W'(1);
              state_reg      <= (WIDTH == 1) ? ST_WAIT : ST_WRITE;
            end
          end
        end

        ST_WRITE: begin
          ram_we    <= 1'b1;
          busy      <= 1'b1;
          ram_addr  <= row_addr;
          ram_wdata <= (col_reg > COL_W'(sample_reg)) ? sample_reg : '0;
          if (col_reg == LAST_COL) begin
            state_reg <= ST_WAIT;
          end else begin
            col_reg <= col_reg + COL_W'(1);
          end
        end

        ST_WAIT: begin
          ram_we    <= 1'b0;
          ram_wdata <= '0;
          ram_addr  <= '0;
          busy      <= 1'b0;
          if (!lower_blank) begin
            state_reg <= ST_VIDEO;
          end
        end

        default: begin
          state_reg <= ST_VIDEO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_scheduler.sv
// tb_fb_scheduler: randomized self-checking bench for fb_scheduler.
// A reduced row width keeps the full scroll wrap (240 line writes) and the
// optional RAM clear short; the reference model tracks only the scroll
// offset and frame count and derives every expected address and data value
// arithmetically from the scrolling waterfall rules.
// Honours FB_SCHED_CLEAR_EN the same way the design does.
module tb_fb_scheduler;

  localparam int W   = 112;
  localparam int H   = 240;
  localparam int AW  = 17;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          visible;
  logic          lower_blank;
  logic [8:0]    x;
  logic [7:0]    y;
  logic          sample_valid;
  logic [7:0]    sample;
  logic          sample_ack;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_we;
  logic [7:0]    scroll_row;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int m_scroll = 0;
  int m_fc = 0;

  fb_scheduler #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .ADDR_W     (AW),
    .SCROLL_DIV (DIV)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .visible      (visible),
    .lower_blank  (lower_blank),
    .x            (x),
    .y            (y),
    .sample_valid (sample_valid),
    .sample       (sample),
    .sample_ack   (sample_ack),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .scroll_row   (scroll_row),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random scan reads: address must follow x/y one cycle later.
  task automatic scan_reads(input int n);
    int exp;
    for (int i = 0; i < n; i++) begin
      visible = 1'($urandom_range(0, 1));
      x = 9'($urandom_range(0, W - 1));
      y = 8'($urandom_range(0, H - 1));
      tick();
      exp = visible ? (int'(x) + ((int'(y) + m_scroll) % H) * W) : 0;
      check_eq("scan_addr", ram_addr, exp);
      check_eq("scan_we", ram_we, 0);
    end
    visible = 1'b0;
  endtask

  // One frame: low phase with scan reads, then lower_blank high for hi_len
  // cycles. The model decides whether this rising edge scrolls.
  task automatic run_frame(input bit sv, input int s, input int hi_len, input int n_scan);
    int row;
    lower_blank = 1'b0;
    visible = 1'b0;
    sample_valid = 1'b0;
    tick();
    scan_reads(n_scan);
    lower_blank = 1'b1;
    sample_valid = sv;
    sample = 8'(s);
    tick();
    m_fc = (m_fc + 1) % DIV;
    if (m_fc == 0 && sv) begin
      row = m_scroll;
      m_scroll = (m_scroll + 1) % H;
      check_eq("ack_pulse", sample_ack, 1);
      sample_valid = 1'b0;
      sample = 8'($urandom_range(0, 255));
      for (int c = 0; c < W; c++) begin
        if (c > 0) check_eq("ack_single", sample_ack, 0);
        check_eq("wr_we", ram_we, 1);
        check_eq("wr_addr", ram_addr, row * W + c);
        check_eq("wr_data", ram_wdata, (c > s) ? s : 0);
        check_eq("wr_busy", busy, 1);
        lower_blank = (c + 1 < hi_len);
        tick();
      end
      check_eq("wr_end_we", ram_we, 0);
      check_eq("wr_end_busy", busy, 0);
      for (int k = W + 1; k < hi_len; k++) begin
        lower_blank = 1'b1;
        tick();
      end
    end else begin
      check_eq("noevt_ack", sample_ack, 0);
      check_eq("noevt_we", ram_we, 0);
      sample_valid = 1'b0;
      for (int k = 1; k < hi_len; k++) tick();
    end
    check_eq("scroll_row", scroll_row, m_scroll);
    lower_blank = 1'b0;
  endtask

  // Burn cheap non-scrolling frames until the next rising edge is a scroll event.
  task automatic to_event_frame();
    while ((m_fc + 1) % DIV != 0) run_frame(1'b1, 0, 1, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int hl;
    resetn = 1'b0;
    visible = 1'b0;
    lower_blank = 1'b0;
    x = '0;
    y = '0;
    sample_valid = 1'b0;
    sample = '0;
    repeat (3) tick();
    check_eq("rst_addr", ram_addr, 0);
    check_eq("rst_wdata", ram_wdata, 0);
    check_eq("rst_we", ram_we, 0);
    check_eq("rst_ack", sample_ack, 0);
    check_eq("rst_scroll", scroll_row, 0);
    check_eq("rst_busy", busy, 0);
    resetn = 1'b1;

`ifdef FB_SCHED_CLEAR_EN
    tick();
    guard = 0;
    while (ram_we !== 1'b1 && guard < 4) begin
      tick();
      guard++;
    end
    check_eq("clear_start", ram_we, 1);
    // lower_blank pulses during the clear must not advance the frame count.
    for (int i = 0; i < W * H; i++) begin
      check_eq("clear_addr", ram_addr, i);
      check_eq("clear_we", ram_we, 1);
      check_eq("clear_data", ram_wdata, 0);
      check_eq("clear_busy", busy, 1);
      lower_blank = (i % 100 == 50);
      sample_valid = 1'b1;
      tick();
    end
    lower_blank = 1'b0;
    sample_valid = 1'b0;
    check_eq("clear_end_we", ram_we, 0);
    check_eq("clear_end_busy", busy, 0);
`else
    repeat (3) begin
      tick();
      check_eq("noclr_busy", busy, 0);
      check_eq("noclr_we", ram_we, 0);
    end
`endif

    // Four frames with a pending sample of 100: only the fourth scrolls,
    // writing row 0 with 0 for c<=100 and 100 above.
    for (int f = 0; f < DIV; f++) run_frame(1'b1, 100, W + 4, 2);
    check_eq("first_scroll", scroll_row, 1);

    while (m_scroll != 5)
      run_frame(1'b1, $urandom_range(0, W + 20), W + 2 + $urandom_range(0, 3), 1);

    // scroll_row=5, y=236 -> row (236+5) mod 240 = 1.
    lower_blank = 1'b0;
    visible = 1'b0;
    tick();
    visible = 1'b1;
    x = 9'd10;
    y = 8'd236;
    tick();
    check_eq("dir_scan", ram_addr, 10 + 1 * W);
    visible = 1'b0;
    tick();
    check_eq("dir_blank", ram_addr, 0);

    // No sample at the scroll event: nothing written, counter still wraps,
    // so the next scroll needs a full DIV frames again.
    to_event_frame();
    run_frame(1'b0, 50, W + 2, 1);
    check_eq("nosample_scroll", scroll_row, 5);
    for (int f = 0; f < DIV - 1; f++) run_frame(1'b1, 50, 2, 1);
    check_eq("nosample_wait", scroll_row, 5);
    run_frame(1'b1, 50, W + 2, 1);
    check_eq("nosample_next", scroll_row, 6);

    // lower_blank falls mid-write: the write still completes.
    to_event_frame();
    run_frame(1'b1, 30, W / 2, 1);

    while (m_scroll != H - 1) begin
      hl = ((m_fc + 1) % DIV == 0)
           ? (($urandom_range(0, 5) == 0) ? W / 2 : W + 2 + $urandom_range(0, 3))
           : $urandom_range(1, 3);
      run_frame($urandom_range(0, 7) != 0, $urandom_range(0, W + 20), hl,
                $urandom_range(0, 2));
    end

    // Event at scroll_row=239 writes the last row and wraps to 0.
    to_event_frame();
    run_frame(1'b1, $urandom_range(0, W), W + 2, 1);
    check_eq("wrap_scroll", scroll_row, 0);

    // Reset in the middle of a line write.
    to_event_frame();
    lower_blank = 1'b0;
    tick();
    lower_blank = 1'b1;
    sample_valid = 1'b1;
    sample = 8'd20;
    tick();
    sample_valid = 1'b0;
    repeat (50) tick();
    check_eq("mid_addr", ram_addr, 50);
    check_eq("mid_we", ram_we, 1);
    resetn = 1'b0;
    tick();
    check_eq("mid_rst_we", ram_we, 0);
    check_eq("mid_rst_scroll", scroll_row, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_addr", ram_addr, 0);
    check_eq("mid_rst_ack", sample_ack, 0);
    resetn = 1'b1;
    lower_blank = 1'b0;
`ifdef FB_SCHED_CLEAR_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("reclear_we", ram_we, 1);
      check_eq("reclear_addr", ram_addr, i);
    end
`else
    tick();
    check_eq("post_rst_we", ram_we, 0);
    check_eq("post_rst_busy", busy, 0);
    check_eq("post_rst_scroll", scroll_row, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
